// File: rtl/fft_peak_finder.sv
// Scans one FFT result RAM over [FIRST_BIN, LAST_BIN] and reports the bin with the largest re^2 + im^2.
// Optional PEAK_THRESH_EN adds a thresh input; only bins with magnitude above it can become the peak.
module fft_peak_finder #(
    parameter int DATA_W    = 14,
    parameter int ADDR_W    = 10,
    parameter int FIRST_BIN = 1,
    parameter int LAST_BIN  = 511,
    parameter int RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2*DATA_W-1:0] fft_q,
`ifdef PEAK_THRESH_EN
    input  logic [2*DATA_W-1:0] thresh,
`endif
    output logic [ADDR_W-1:0]   rd_addr,
    output logic                busy,
    output logic                done,
    output logic                peak_valid,
    output logic [ADDR_W-1:0]   peak_bin,
    output logic [2*DATA_W-1:0] peak_mag,
    output logic [1:0]          state_dbg
);
    // Handshake: start is a single-cycle request, accepted only in IDLE and dropped otherwise;
    // done is a single-cycle result strobe with no backpressure, and peak_* hold until the next done.

    localparam int MAG_W = 2*DATA_W;
    localparam int SQ_W  = MAG_W - 1;
    localparam logic [ADDR_W-1:0] FIRST_A    = ADDR_W'(FIRST_BIN);
    localparam logic [ADDR_W-1:0] LAST_A     = ADDR_W'(LAST_BIN);
    localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT + 2);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [2:0] drain_cnt;
    logic       accept;
    logic       finish;

    assign accept    = (state == IDLE) && start;
    assign finish    = (state == DRAIN) && (drain_cnt == DRAIN_LAST);
    assign busy      = (state == SCAN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (rd_addr == LAST_A) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_addr   <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                rd_addr <= FIRST_A;
            else if (state == SCAN && rd_addr != LAST_A)
                rd_addr <= rd_addr + ADDR_W'(1);
            drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
        end
    end

    // Bin tag travels alongside the RAM read so each returned word knows its index.
    logic [ADDR_W-1:0] tag_bin [RD_LAT];
    logic [RD_LAT-1:0] tag_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_bin[i] <= '0;
        end else begin
            tag_vld[0] <= (state == SCAN);
            tag_bin[0] <= rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_bin[i] <= tag_bin[i-1];
            end
        end
    end

    // Stage A: squares are non-negative and at most 2**(2*DATA_W-2), so SQ_W bits suffice.
    logic signed [MAG_W-1:0] re_x, im_x;
    logic [SQ_W-1:0]         re_sq, im_sq;
    logic                    a_vld;
    logic [ADDR_W-1:0]       a_bin;

    assign re_x = {{DATA_W{fft_q[MAG_W-1]}},  fft_q[MAG_W-1:DATA_W]};
    assign im_x = {{DATA_W{fft_q[DATA_W-1]}}, fft_q[DATA_W-1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            a_vld <= 1'b0;
            a_bin <= '0;
            re_sq <= '0;
            im_sq <= '0;
        end else begin
            a_vld <= tag_vld[RD_LAT-1];
            a_bin <= tag_bin[RD_LAT-1];
            re_sq <= SQ_W'(re_x * re_x);
            im_sq <= SQ_W'(im_x * im_x);
        end
    end

    // Stage B: sum and strict-greater compare, so ties keep the earliest bin.
    logic [MAG_W-1:0]  mag_sum;
    logic              qualify;
    logic              take;
    logic              max_vld;
    logic [ADDR_W-1:0] max_bin;
    logic [MAG_W-1:0]  max_mag;

    assign mag_sum = {1'b0, re_sq} + {1'b0, im_sq};

`ifdef PEAK_THRESH_EN
    logic [MAG_W-1:0] thresh_q;
    always_ff @(posedge clk) begin
        if (reset)       thresh_q <= '0;
        else if (accept) thresh_q <= thresh;
    end
    assign qualify = (mag_sum > thresh_q);
`else
    assign qualify = 1'b1;
`endif

    assign take = a_vld && qualify && (!max_vld || mag_sum > max_mag);

    always_ff @(posedge clk) begin
        if (reset || accept) begin
            max_vld <= 1'b0;
            max_bin <= '0;
            max_mag <= '0;
        end else if (take) begin
            max_vld <= 1'b1;
            max_bin <= a_bin;
            max_mag <= mag_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_mag   <= '0;
        end else if (finish) begin
            peak_valid <= max_vld;
            peak_bin   <= max_bin;
            peak_mag   <= max_mag;
        end
    end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Bench for fft_peak_finder: RAM model, table of spectra with expected peaks, scoreboard queue,
// plus hand sequences for restart-while-busy and mid-scan reset.
module tb_fft_peak_finder;
    localparam int DATA_W    = 14;
    localparam int ADDR_W    = 10;
    localparam int FIRST_BIN = 1;
    localparam int LAST_BIN  = 511;
    localparam int RD_LAT    = 1;
    localparam int MAG_W     = 2*DATA_W;
    localparam int N         = LAST_BIN - FIRST_BIN + 1;
    localparam int LAT       = N + RD_LAT + 3;
    localparam int EXP_W     = 1 + ADDR_W + MAG_W;

    logic              clk;
    logic              reset;
    logic              start;
    logic [MAG_W-1:0]  fft_q;
    logic [MAG_W-1:0]  thresh_v;
    logic [ADDR_W-1:0] rd_addr;
    logic              busy;
    logic              done;
    logic              peak_valid;
    logic [ADDR_W-1:0] peak_bin;
    logic [MAG_W-1:0]  peak_mag;
    logic [1:0]        state_dbg;

    logic [MAG_W-1:0] mem [1 << ADDR_W];

    int n_cmp;
    int n_err;
    logic [EXP_W-1:0] exp_q[$];

    typedef struct {
        int          pat;
        bit          use_model;
        bit          restart;
        bit          exp_valid;
        int          exp_bin;
        int          exp_mag;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) fft_q <= mem[rd_addr];

    fft_peak_finder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIRST_BIN(FIRST_BIN),
        .LAST_BIN(LAST_BIN), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .fft_q(fft_q),
`ifdef PEAK_THRESH_EN
        .thresh(thresh_v),
`endif
        .rd_addr(rd_addr),
        .busy(busy),
        .done(done),
        .peak_valid(peak_valid),
        .peak_bin(peak_bin),
        .peak_mag(peak_mag),
        .state_dbg(state_dbg)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [MAG_W-1:0] cpx(input int re, input int im);
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] i;
        r = re[DATA_W-1:0];
        i = im[DATA_W-1:0];
        return {r, i};
    endfunction

    task automatic load_pattern(input int p);
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        case (p)
            0: mem[37] = cpx(100, -50);
            1: begin
                mem[0]   = cpx(8191, 0);
                mem[20]  = cpx(0, 1000);
                mem[300] = cpx(0, 1000);
            end
            2: begin
                for (int i = 0; i < (1 << ADDR_W); i++)
                    mem[i] = cpx(int'($urandom_range(6)) - 3, int'($urandom_range(6)) - 3);
                mem[511] = cpx(-8192, -8192);
            end
            4: for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = MAG_W'($urandom);
            6: begin
                mem[1]   = cpx(3, 4);
                mem[512] = cpx(-8192, -8192);
                mem[0]   = cpx(-8192, 8191);
            end
            default: ;
        endcase
    endtask

    // Reference: exhaustive max over the scanned bins, first occurrence wins ties.
    function automatic logic [EXP_W-1:0] model();
        bit bv;
        int bb;
        int bm;
        bv = 1'b0;
        bb = 0;
        bm = 0;
        for (int b = FIRST_BIN; b <= LAST_BIN; b++) begin
            int re;
            int im;
            int mag;
            bit qual;
            re  = int'($signed(mem[b][MAG_W-1:DATA_W]));
            im  = int'($signed(mem[b][DATA_W-1:0]));
            mag = re*re + im*im;
`ifdef PEAK_THRESH_EN
            qual = (mag > int'(thresh_v));
`else
            qual = 1'b1;
`endif
            if (qual && (!bv || mag > bm)) begin
                bv = 1'b1;
                bb = b;
                bm = mag;
            end
        end
        return {bv, ADDR_W'(bb), MAG_W'(bm)};
    endfunction

    // Drives one start pulse and follows the scan to completion, checking timing and results.
    task automatic run_scan(input bit restart, input logic [EXP_W-1:0] prev);
        int done_at;
        int done_cnt;
        int addr_err;
        int busy_err;
        int hold_err;
        logic [EXP_W-1:0] got;
        logic [EXP_W-1:0] exp;
        done_at  = -1;
        done_cnt = 0;
        addr_err = 0;
        busy_err = 0;
        hold_err = 0;
        got      = '0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int cyc = 0; cyc <= LAT + 6; cyc++) begin
            int exp_addr;
            exp_addr = (cyc < N) ? FIRST_BIN + cyc : LAST_BIN;
            if (rd_addr !== ADDR_W'(exp_addr)) addr_err++;
            if (busy !== (cyc < LAT)) busy_err++;
            if (cyc < LAT && {peak_valid, peak_bin, peak_mag} !== prev) hold_err++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = cyc;
                    got = {peak_valid, peak_bin, peak_mag};
                end
            end
            start = (restart && cyc == 100);
            @(negedge clk);
        end
        start = 1'b0;
        exp = exp_q.pop_front();
        chk("done_latency", 64'(done_at), 64'(LAT));
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("rd_addr_seq_errors", 64'(addr_err), 64'd0);
        chk("busy_errors", 64'(busy_err), 64'd0);
        chk("peak_hold_errors", 64'(hold_err), 64'd0);
        chk("peak_valid", 64'(got[EXP_W-1]), 64'(exp[EXP_W-1]));
        chk("peak_bin", 64'(got[EXP_W-2:MAG_W]), 64'(exp[EXP_W-2:MAG_W]));
        chk("peak_mag", 64'(got[MAG_W-1:0]), 64'(exp[MAG_W-1:0]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t tbl [8];
        logic [EXP_W-1:0] prev;
        logic [EXP_W-1:0] e;
        int done_seen;

        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b1;
        start    = 1'b0;
        thresh_v = '0;
        load_pattern(3);

        tbl[0] = '{pat: 0, use_model: 0, restart: 0, exp_valid: 1, exp_bin: 37,  exp_mag: 12500};
        tbl[1] = '{pat: 1, use_model: 0, restart: 0, exp_valid: 1, exp_bin: 20,  exp_mag: 1000000};
        tbl[2] = '{pat: 2, use_model: 0, restart: 0, exp_valid: 1, exp_bin: 511, exp_mag: 134217728};
`ifdef PEAK_THRESH_EN
        tbl[3] = '{pat: 3, use_model: 0, restart: 0, exp_valid: 0, exp_bin: 0,   exp_mag: 0};
`else
        tbl[3] = '{pat: 3, use_model: 0, restart: 0, exp_valid: 1, exp_bin: 1,   exp_mag: 0};
`endif
        tbl[4] = '{pat: 4, use_model: 1, restart: 0, exp_valid: 0, exp_bin: 0,   exp_mag: 0};
        tbl[5] = '{pat: 0, use_model: 0, restart: 1, exp_valid: 1, exp_bin: 37,  exp_mag: 12500};
        tbl[6] = '{pat: 6, use_model: 0, restart: 0, exp_valid: 1, exp_bin: 1,   exp_mag: 25};
        tbl[7] = '{pat: 4, use_model: 1, restart: 0, exp_valid: 0, exp_bin: 0,   exp_mag: 0};

        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_rd_addr", 64'(rd_addr), 64'd0);
        chk("reset_peak_valid", 64'(peak_valid), 64'd0);
        chk("reset_peak_bin", 64'(peak_bin), 64'd0);
        chk("reset_peak_mag", 64'(peak_mag), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        prev = '0;
        for (int t = 0; t < 8; t++) begin
            load_pattern(tbl[t].pat);
            if (tbl[t].use_model)
                e = model();
            else
                e = {tbl[t].exp_valid, ADDR_W'(tbl[t].exp_bin), MAG_W'(tbl[t].exp_mag)};
            exp_q.push_back(e);
            run_scan(tbl[t].restart, prev);
            prev = e;
        end

        // Mid-scan reset: outputs clear on the next cycle and the aborted scan never reports.
        load_pattern(0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (200) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_rd_addr", 64'(rd_addr), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_peak_valid", 64'(peak_valid), 64'd0);
        chk("midreset_peak_bin", 64'(peak_bin), 64'd0);
        chk("midreset_peak_mag", 64'(peak_mag), 64'd0);
        reset = 1'b0;
        done_seen = 0;
        repeat (LAT) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        chk("midreset_no_done", 64'(done_seen), 64'd0);

        load_pattern(1);
        exp_q.push_back({1'b1, ADDR_W'(20), MAG_W'(1000000)});
        run_scan(1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
